// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// It registers the operands, then returns the result on one response channel tagged with the requester id.
module alu_arbiter #(
  parameter int DW   = 4,
  parameter int OPW  = 3,
  parameter int RW   = 2 * DW,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_op,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_op,
  output logic            req1_ready,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [RW-1:0]   alu_rslt,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [RW-1:0]   rsp_rslt,
  input  logic            rsp_ready,
  output logic [CNTW-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [RW-1:0]   rsp_rslt_q, rsp_rslt_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  logic grant_vld;
  logic grant_id;

  // On a tie the requester opposite the last winner is granted.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
  end

  assign req0_ready = !rst && (state_q == IDLE) && grant_vld && !grant_id;
  assign req1_ready = !rst && (state_q == IDLE) && grant_vld &&  grant_id;

  // NOTE: every _d gets a default (hold) first, so no path leaves a value
  // unassigned and no latch is inferred; blocking '=' is correct in always_comb.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rslt_d  = rsp_rslt_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          alu_a_d   = grant_id ? req1_a  : req0_a;
          alu_b_d   = grant_id ? req1_b  : req0_b;
          alu_op_d  = grant_id ? req1_op : req0_op;
          rsp_id_d  = grant_id;
          rr_last_d = grant_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_rslt_d  = alu_rslt;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rslt_q  <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rslt_q  <= rsp_rslt_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rslt  = rsp_rslt_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; it includes a small reference ALU driven from the DUT's alu_* outputs.
// The expected values are worked out by hand for each step.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_rslt;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [7:0] rsp_rslt, done_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rslt(alu_rslt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rslt(rsp_rslt), .rsp_ready(rsp_ready),
    .done_cnt(done_cnt)
  );

  // Reference ALU: operands zero-extended to 8 bits, so subtraction and the inversions wrap in 8 bits.
  always_comb begin
    logic [7:0] ea, eb;
    ea = {4'b0, alu_a};
    eb = {4'b0, alu_b};
    case (alu_op)
      3'd0:    alu_rslt = ea + eb;
      3'd1:    alu_rslt = ea - eb;
      3'd2:    alu_rslt = ea * eb;
      3'd3:    alu_rslt = ea & eb;
      3'd4:    alu_rslt = ea | eb;
      3'd5:    alu_rslt = ~ea;
      3'd6:    alu_rslt = ea ^ eb;
      default: alu_rslt = ~(ea ^ eb);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd7; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
    #1;
    check("ready0_in_rst", req0_ready, 0);
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_rslt", rsp_rslt, 0);

    // Test 1: a single add from req0.
    rst = 1'b0; #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("t1_alu_a", alu_a, 9);
    check("t1_alu_b", alu_b, 7);
    check("t1_exec_rsp_valid", rsp_valid, 0);
    check("t1_exec_ready0", req0_ready, 0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_rslt", rsp_rslt, 8'h10);
    rsp_ready = 1'b1;
    tick();
    check("t1_done_cnt", done_cnt, 1);
    check("t1_rsp_cleared", rsp_valid, 0);

    // Test 2: a tie just after reset goes to req0, then req1, then req0 again.
    rsp_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd5;  req0_op = 3'd1;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15; req1_op = 3'd2;
    #1;
    check("t2_tie1_ready0", req0_ready, 1);
    check("t2_tie1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    check("t2_sub_rsp_id", rsp_id, 0);
    check("t2_sub_rslt", rsp_rslt, 8'hFE);
    check("t2_resp_ready1", req1_ready, 0);
    rsp_ready = 1'b1;
    tick();
    check("t2_req1_ready", req1_ready, 1);
    tick();
    tick();
    check("t2_mul_rsp_id", rsp_id, 1);
    check("t2_mul_rslt", rsp_rslt, 8'hE1);
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3; req0_op = 3'd3;
    tick();
    check("t2_tie3_ready0", req0_ready, 1);
    check("t2_tie3_ready1", req1_ready, 0);
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();

    // Test 3: a stalled response must hold while rsp_ready is low.
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_id", rsp_id, 0);
      check("t3_hold_rslt", rsp_rslt, 8'h02);
      check("t3_hold_ready1", req1_ready, 0);
      check("t3_hold_done", done_cnt, 2);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t3_done_inc", done_cnt, 3);
    check("t3_rsp_cleared", rsp_valid, 0);
    check("t3_idle_ready1", req1_ready, 1);

    // Test 4: not-a and xnor wrap to 8 bits.
    req1_a = 4'b0101; req1_b = 4'd0; req1_op = 3'd5;
    tick();
    tick();
    check("t4_nota_rslt", rsp_rslt, 8'hFA);
    check("t4_nota_id", rsp_id, 1);
    req1_a = 4'hA; req1_b = 4'h5; req1_op = 3'd7;
    tick();
    check("t4_done", done_cnt, 4);
    check("t4_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("t4_alu_op", alu_op, 7);
    tick();
    check("t4_xnor_rslt", rsp_rslt, 8'hF0);
    check("t4_alu_a_held", alu_a, 4'hA);
    tick();
    check("t4_done2", done_cnt, 5);

    // Test 5: reset during EXEC and during RESP abandons the operation.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd0;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_exec_rsp_valid", rsp_valid, 0);
    check("t5_exec_done", done_cnt, 0);
    check("t5_exec_alu_a", alu_a, 0);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 3'd0;
    #1;
    check("t5_grant0", req0_ready, 1);
    check("t5_grant1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("t5_resp_valid", rsp_valid, 1);
    check("t5_resp_rslt", rsp_rslt, 8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_resp_rsp_valid", rsp_valid, 0);
    check("t5_resp_done", done_cnt, 0);
    check("t5_resp_rslt_rst", rsp_rslt, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'd2; req0_b = 4'd3; req0_op = 3'd0;
    req1_a = 4'hC; req1_b = 4'h5; req1_op = 3'd6;
    #1;
    check("t5_after_rst_ready0", req0_ready, 1);
    check("t5_after_rst_ready1", req1_ready, 0);

    // Test 6: 256 back-to-back ops alternate grants and wrap the counter.
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic exp_id;
      exp_id = i[0];
      check("t6_done_before", done_cnt, i[7:0]);
      check("t6_ready0", req0_ready, !exp_id);
      check("t6_ready1", req1_ready, exp_id);
      tick();
      tick();
      check("t6_rsp_id", rsp_id, exp_id);
      check("t6_rsp_rslt", rsp_rslt, exp_id ? 8'h09 : 8'h05);
      tick();
    end
    check("t6_done_wrap", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
